instr_mem_banked: RTL and testbench

INSTR_MEM_BANKED -- requirements
Module: instr_mem_banked

---
 rtl/instr_mem_pkg.sv | 17 +
 rtl/instr_mem_bank.sv | 26 ++
 rtl/instr_mem_banked.sv | 92 +++++++++
 tb/tb_instr_mem_banked.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the banked instruction memory.
package instr_mem_pkg;

  localparam int DEFAULT_INSTR_BYTES = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  // Output lane 0 (MSB) carries the byte at the request address; later lanes
  // walk forward through the banks, wrapping at the bank count.
  function automatic int lane_bank(int lane, int off, int nbanks);
    return (lane + off) % nbanks;
  endfunction

endpackage

// File: rtl/instr_mem_bank.sv
// One byte-wide bank: synchronous write, synchronous registered read.
module instr_mem_bank #(
  parameter int ROW_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [ROW_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic             re,
  input  logic [ROW_W-1:0] raddr,
  output logic [7:0]       q
);

  logic [7:0] mem [2**ROW_W];

  // Storage is never reset so a loaded program survives rst.
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Read samples the pre-write array, so a same-edge write is not visible.
  always_ff @(posedge clk or posedge rst)
    if (rst)     q <= '0;
    else if (re) q <= mem[raddr];

endmodule

// File: rtl/instr_mem_banked.sv
// Banked instruction memory: one-cycle fetch of any alignment, EMPTY/FULL output stage.
// Define INSTR_MEM_ALIGN_CHECK_EN to flag unaligned fetches as errors.
module instr_mem_banked
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int INSTR_BYTES = DEFAULT_INSTR_BYTES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [8*INSTR_BYTES-1:0] rsp_data,
  output logic                     rsp_err,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [7:0]               wr_data
);

  localparam int SH    = $clog2(INSTR_BYTES);
  localparam int OFF_W = (SH > 0) ? SH : 1;
  localparam int ROW_W = ADDR_W - SH;
  localparam int DW    = 8 * INSTR_BYTES;

  out_state_t                  state;
  logic                        accept, err_n, err_q;
  logic [OFF_W-1:0]            off, off_q, wr_off;
  logic [ROW_W-1:0]            row, wr_row;
  logic [INSTR_BYTES-1:0][7:0] q;
  logic [DW-1:0]               data;

  assign req_ready = (state == EMPTY) || rsp_ready;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == FULL);

  assign off    = OFF_W'(req_addr[ADDR_W-1:0] & ADDR_W'(INSTR_BYTES - 1));
  assign row    = ROW_W'(req_addr[ADDR_W-1:0] >> SH);
  assign wr_off = OFF_W'(wr_addr & ADDR_W'(INSTR_BYTES - 1));
  assign wr_row = ROW_W'(wr_addr >> SH);

`ifdef INSTR_MEM_ALIGN_CHECK_EN
  assign err_n = (|req_addr[31:ADDR_W]) || (off != '0);
`else
  assign err_n = |req_addr[31:ADDR_W];
`endif

  // Banks below the offset hold the tail of the instruction in the next row;
  // the row counter wraps naturally at the top of memory.
  for (genvar b = 0; b < INSTR_BYTES; b++) begin : g_bank
    logic [ROW_W-1:0] rd_row;
    assign rd_row = (OFF_W'(b) >= off) ? row : row + ROW_W'(1);

    instr_mem_bank #(.ROW_W(ROW_W)) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_en && (wr_off == OFF_W'(b))),
      .waddr (wr_row),
      .wdata (wr_data),
      .re    (accept),
      .raddr (rd_row),
      .q     (q[b])
    );
  end

  // Bank read registers only load on accept, so they double as the held response.
  always_comb begin
    data = '0;
    for (int l = 0; l < INSTR_BYTES; l++)
      data[8*(INSTR_BYTES-1-l) +: 8] = q[lane_bank(l, int'(off_q), INSTR_BYTES)];
  end

  assign rsp_data = err_q ? '0 : data;
  assign rsp_err  = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      err_q <= 1'b0;
      off_q <= '0;
    end else if (accept) begin
      state <= FULL;
      err_q <= err_n;
      off_q <= off;
    end else if (rsp_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_instr_mem_banked.sv
// Randomized + directed bench for instr_mem_banked against a byte-array reference model.
module tb_instr_mem_banked;

  localparam int AW = 10;
  localparam int IB = 4;
  localparam int DW = 8 * IB;
  localparam int MB = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, wr_en;
  logic [31:0]   req_addr;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  instr_mem_banked #(.ADDR_W(AW), .INSTR_BYTES(IB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]    mem [MB];
  bit            m_full;
  logic [DW-1:0] m_data;
  bit            m_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Instruction = consecutive bytes from the address, first byte most significant.
  function automatic void ref_fetch(input logic [31:0] a, output logic [DW-1:0] d, output bit e);
    d = '0;
    e = (a >> AW) != 0;
`ifdef INSTR_MEM_ALIGN_CHECK_EN
    if ((a % IB) != 0) e = 1'b1;
`endif
    if (!e)
      for (int i = 0; i < IB; i++) begin
        int idx;
        idx = int'((a + 32'(i)) % MB);
        d = {d[DW-9:0], mem[idx]};
      end
  endfunction

  // One clock: drive, check outputs mid-cycle, advance the model at the edge.
  task automatic cyc(input bit rv, input logic [31:0] ra, input bit rr,
                     input bit we = 1'b0, input logic [AW-1:0] wa = '0, input logic [7:0] wd = '0);
    logic [DW-1:0] d;
    bit e, acc;
    req_valid = rv; req_addr = ra; rsp_ready = rr;
    wr_en = we; wr_addr = wa; wr_data = wd;
    @(negedge clk);
    chk("req_ready", req_ready, 64'(!m_full || rr));
    chk("rsp_valid", rsp_valid, 64'(m_full));
    if (m_full) begin
      chk("rsp_data", rsp_data, 64'(m_data));
      chk("rsp_err", rsp_err, 64'(m_err));
    end
    @(posedge clk);
    acc = rv && (!m_full || rr);
    if (acc) begin
      ref_fetch(ra, d, e);
      m_full = 1'b1; m_data = d; m_err = e;
    end else if (rr) begin
      m_full = 1'b0;
    end
    if (we) mem[wa] = wd;
    #1;
  endtask

  initial begin
    logic [31:0] ra;
    logic [7:0]  seq [8];
    rst = 1'b1; req_valid = 0; req_addr = '0; rsp_ready = 0;
    wr_en = 0; wr_addr = '0; wr_data = '0;
    m_full = 0; m_data = '0; m_err = 0;
    #12;
    chk("rst_valid", rsp_valid, 64'(0));
    chk("rst_data", rsp_data, 64'(0));
    chk("rst_err", rsp_err, 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Fill every byte so random fetches never read uninitialised storage.
    for (int i = 0; i < MB; i++) cyc(0, '0, 1, 1, AW'(i), 8'($urandom));
    seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 8; i++) cyc(0, '0, 1, 1, AW'(i), seq[i]);
    cyc(0, '0, 1, 1, AW'(10'h3FE), 8'hAA);
    cyc(0, '0, 1, 1, AW'(10'h3FF), 8'hBB);

    cyc(1, 32'h0, 1);
    chk("fetch0", rsp_data, 64'h11223344);
    chk("fetch0_err", rsp_err, 64'(0));
    cyc(1, 32'h2, 1);
`ifdef INSTR_MEM_ALIGN_CHECK_EN
    chk("fetch2_err", rsp_err, 64'(1));
    chk("fetch2", rsp_data, 64'(0));
`else
    chk("fetch2", rsp_data, 64'h33445566);
    chk("fetch2_err", rsp_err, 64'(0));
`endif
    cyc(1, 32'h3FE, 1);
`ifndef INSTR_MEM_ALIGN_CHECK_EN
    chk("fetch_wrap", rsp_data, 64'hAABB1122);
`endif

    // Stall with a pending request that must not be taken.
    cyc(1, 32'h0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 32'h4, 0);
      chk("hold_data", rsp_data, 64'h11223344);
      chk("hold_ready", req_ready, 64'(0));
    end
    cyc(1, 32'h4, 1);
    chk("fetch4", rsp_data, 64'h55667788);

    cyc(1, 32'h400, 1);
    chk("oob_err", rsp_err, 64'(1));
    chk("oob_data", rsp_data, 64'(0));
    cyc(1, 32'h0, 1, 1, '0, 8'h99);
    chk("rd_old", rsp_data, 64'h11223344);
    cyc(1, 32'h0, 1);
    chk("rd_new", rsp_data, 64'h99223344);

    // Async reset while holding a response.
    cyc(0, '0, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", rsp_valid, 64'(0));
    chk("arst_data", rsp_data, 64'(0));
    chk("arst_err", rsp_err, 64'(0));
    m_full = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1, 32'h0, 1);
    chk("post_rst", rsp_data, 64'h99223344);

    // A write while holding must not disturb the held word.
    cyc(0, '0, 0, 1, AW'(1), 8'h5A);
    chk("hold_wr", rsp_data, 64'h99223344);
    cyc(1, 32'h0, 1);
    chk("after_wr", rsp_data, 64'h995A3344);

    for (int i = 0; i < 600; i++) begin
      ra = 32'($urandom_range(0, MB - 1));
      if ($urandom_range(0, 7) == 0) ra = ra | (32'h400 << $urandom_range(0, 21));
      cyc(bit'($urandom_range(0, 3) != 0), ra, bit'($urandom_range(0, 2) != 0),
          bit'($urandom_range(0, 2) == 0), AW'($urandom), 8'($urandom));
    end
    cyc(0, '0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
